// File: rtl/id_entry_arbiter.sv
// Two-port entry arbiter: injector has fixed priority over fetch, subject to a fetch starvation
// guard and injector burst locking. Optional perf counters are enabled by ID_ARB_PERF_EN.
module id_entry_arbiter #(
    parameter int unsigned ENTRY_W      = 64,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] fetch_data_i,
    input  logic               fetch_valid_i,
    output logic               fetch_ready_o,
    input  logic [ENTRY_W-1:0] inj_data_i,
    input  logic               inj_valid_i,
    input  logic               inj_last_i,
    output logic               inj_ready_o,
    output logic [ENTRY_W-1:0] out_data_o,
    output logic               out_valid_o,
    output logic               out_src_o,
    input  logic               out_ready_i
`ifdef ID_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]   perf_fetch_cnt_o,
    output logic [CNT_W-1:0]   perf_inj_cnt_o
`endif
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e             state_q, state_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic               out_valid_q;
    logic [ENTRY_W-1:0] out_data_q;
    logic               out_src_q;

    logic space, can_acc, starved;
    logic grant_f, grant_i, f_acc, i_acc;

    assign space   = !out_valid_q || out_ready_i;
    // Readys are forced low while reset is held, since the reset is asynchronous.
    assign can_acc = space && !flush_i && !rst_i;
    assign starved = (starve_q == SW'(STARVE_LIMIT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (flush_i) begin
            state_d  = StIdle;
            starve_d = '0;
        end else begin
            if (i_acc) begin
                state_d = inj_last_i ? StIdle : StBurst;
            end
            if (state_q == StIdle) begin
                if (fetch_valid_i && !f_acc) begin
                    if (!starved) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else begin
                    starve_d = '0;
                end
            end
        end
    end

    always_comb begin
        grant_f = 1'b0;
        grant_i = 1'b0;
        unique case (state_q)
            StIdle: begin
                grant_i = inj_valid_i && !(fetch_valid_i && starved);
                grant_f = fetch_valid_i && !grant_i;
            end
            StBurst: begin
                grant_i = inj_valid_i;
            end
            default: ;
        endcase
        fetch_ready_o = can_acc && grant_f;
        inj_ready_o   = can_acc && grant_i;
    end

    assign f_acc = fetch_ready_o;
    assign i_acc = inj_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (f_acc || i_acc) begin
            out_valid_q <= 1'b1;
            out_data_q  <= i_acc ? inj_data_i : fetch_data_i;
            out_src_q   <= i_acc;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;

`ifdef ID_ARB_PERF_EN
    logic [CNT_W-1:0] perf_fetch_q, perf_inj_q;

    // Cleared by reset only; flush does not touch the counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_fetch_q <= '0;
            perf_inj_q   <= '0;
        end else begin
            if (f_acc) perf_fetch_q <= perf_fetch_q + 1'b1;
            if (i_acc) perf_inj_q   <= perf_inj_q + 1'b1;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_inj_cnt_o   = perf_inj_q;
`else
    // Perf counters not built.
`endif

endmodule

// File: tb/tb_id_entry_arbiter.sv
// Scoreboard bench for id_entry_arbiter: a rule-level model predicts grants and queues expected
// entries; a separate monitor pops and compares whenever the consumer takes an entry.
module tb_id_entry_arbiter;

    localparam int unsigned EW  = 64;
    localparam int unsigned LIM = 4;
    localparam int unsigned CW  = 32;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          flush_i = 1'b0;
    logic [EW-1:0] fetch_data_i = '0;
    logic          fetch_valid_i = 1'b0;
    logic          fetch_ready_o;
    logic [EW-1:0] inj_data_i = '0;
    logic          inj_valid_i = 1'b0;
    logic          inj_last_i = 1'b0;
    logic          inj_ready_o;
    logic [EW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_src_o;
    logic          out_ready_i = 1'b0;
`ifdef ID_ARB_PERF_EN
    logic [CW-1:0] perf_fetch_cnt_o, perf_inj_cnt_o;
    int            m_pf, m_pi;
`endif

    id_entry_arbiter #(
        .ENTRY_W(EW),
        .STARVE_LIMIT(LIM),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .fetch_data_i(fetch_data_i),
        .fetch_valid_i(fetch_valid_i),
        .fetch_ready_o(fetch_ready_o),
        .inj_data_i(inj_data_i),
        .inj_valid_i(inj_valid_i),
        .inj_last_i(inj_last_i),
        .inj_ready_o(inj_ready_o),
        .out_data_o(out_data_o),
        .out_valid_o(out_valid_o),
        .out_src_o(out_src_o),
        .out_ready_i(out_ready_i)
`ifdef ID_ARB_PERF_EN
        ,
        .perf_fetch_cnt_o(perf_fetch_cnt_o),
        .perf_inj_cnt_o(perf_inj_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW:0] exp_q[$];   // {src, data}
    bit          m_burst;
    bit          m_held;
    int          m_starve;

    task automatic chk(input string name, input logic [EW:0] act, input logic [EW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_burst  = 1'b0;
        m_held   = 1'b0;
        m_starve = 0;
        exp_q.delete();
`ifdef ID_ARB_PERF_EN
        m_pf = 0;
        m_pi = 0;
`endif
    endtask

    // Assert reset asynchronously with all inputs active, then release with inputs idle.
    task automatic do_reset();
        @(negedge clk);
        fetch_valid_i = 1'b1;
        inj_valid_i   = 1'b1;
        inj_last_i    = 1'b0;
        out_ready_i   = 1'b1;
        rst_i         = 1'b1;
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_out_src", out_src_o, 0);
        chk("rst_fetch_ready", fetch_ready_o, 0);
        chk("rst_inj_ready", inj_ready_o, 0);
`ifdef ID_ARB_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt_o, 0);
        chk("rst_perf_inj", perf_inj_cnt_o, 0);
`endif
        model_reset();
        @(negedge clk);
        fetch_valid_i = 1'b0;
        inj_valid_i   = 1'b0;
        out_ready_i   = 1'b0;
        flush_i       = 1'b0;
        rst_i         = 1'b0;
    endtask

    // One clock of stimulus; predicts readys from the arbitration rules and queues accepts.
    task automatic cycle(input bit fv, input bit iv, input bit il, input bit ordy, input bit fl);
        logic [EW-1:0] fd, id;
        bit ok, gi, gf, fa, ia;
        @(negedge clk);
        fd = {$urandom, $urandom};
        id = {$urandom, $urandom};
        fetch_valid_i = fv;
        fetch_data_i  = fd;
        inj_valid_i   = iv;
        inj_data_i    = id;
        inj_last_i    = il;
        out_ready_i   = ordy;
        flush_i       = fl;
        #1;
        chk("out_valid", out_valid_o, m_held);
        ok = (!m_held || ordy) && !fl;
        if (m_burst) begin
            gi = iv;
            gf = 1'b0;
        end else begin
            gi = iv && !(fv && m_starve == LIM);
            gf = fv && !gi;
        end
        fa = ok && gf;
        ia = ok && gi;
        chk("fetch_ready", fetch_ready_o, fa);
        chk("inj_ready", inj_ready_o, ia);
        if (fl) begin
            if (m_held && !ordy && exp_q.size() > 0) void'(exp_q.pop_front());
            m_burst  = 1'b0;
            m_starve = 0;
            m_held   = 1'b0;
        end else begin
            if (!m_burst) m_starve = (fv && !fa) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
            if (ia) m_burst = !il;
            if (fa) exp_q.push_back({1'b0, fd});
            if (ia) exp_q.push_back({1'b1, id});
            m_held = fa || ia || (m_held && !ordy);
`ifdef ID_ARB_PERF_EN
            if (fa) m_pf++;
            if (ia) m_pi++;
`endif
        end
    endtask

    // Monitor: compare the held entry whenever the consumer takes it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_i && out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_entry: got %0h expected none", {out_src_o, out_data_o});
                end else begin
                    chk("out_entry", {out_src_o, out_data_o}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [EW-1:0] held_data;
        model_reset();
        do_reset();

        // Fixed priority with starvation guard: I,I,I,I,F repeating.
        repeat (10) cycle(1, 1, 1, 1, 0);

        // Backpressure: load an F entry, then stall with F valid; data must stay put.
        cycle(1, 0, 1, 0, 0);
        held_data = out_data_o;
        repeat (5) cycle(1, 0, 1, 0, 0);
        chk("stall_data_stable", {1'b0, out_data_o}, {1'b0, held_data});
        cycle(1, 1, 1, 1, 0);

        // Burst lock: F must wait until the last I beat is accepted.
        cycle(0, 1, 0, 1, 0);
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 0, 1, 0);
        cycle(1, 1, 1, 1, 0);
        cycle(1, 1, 1, 1, 0);

        // Flush mid-burst, then F wins with I idle.
        cycle(0, 1, 0, 1, 0);
        cycle(1, 1, 0, 1, 1);
        cycle(1, 0, 0, 1, 0);
        cycle(1, 0, 0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0);
        end

`ifdef ID_ARB_PERF_EN
        cycle(0, 0, 0, 1, 1);
        chk("perf_fetch", perf_fetch_cnt_o, m_pf);
        chk("perf_inj", perf_inj_cnt_o, m_pi);
`endif
        repeat (3) cycle(0, 0, 0, 1, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
